rescale_ctrl: RTL
=================

RESCALE_CTRL -- requirements
Module: rescale_ctrl

Interface
REQ-001 Parameter NUM_WIDTH, default 33, width of MAC/ADD number stream.
REQ-002 Parameter IMG_WIDTH, default 16, width of image data stream.
REQ-003 Parameter LATENCY, default 4, fixed cycle latency of the attached rescale datapath.
REQ-004 Parameter DEPTH, default 8, result FIFO depth; SHALL be a power of two >= LATENCY.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 cfg_shift  input  8  requested shift value.
REQ-009 cfg_valid  input  1  shift update request; held until cfg_ready.
REQ-010 cfg_ready  output  1  one-cycle pulse when cfg_shift is applied.
REQ-011 cfg_clamp  output  1  sticky flag: a request exceeded NUM_WIDTH-IMG_WIDTH.
REQ-012 up_data  input  NUM_WIDTH  upstream number.
REQ-013 up_valid / up_rdy  input / output  1  upstream handshake; transfer when both high.
REQ-014 rs_shift  output  8  shift to the datapath, registered.
REQ-015 rs_data  output  NUM_WIDTH  number to the datapath, combinationally equal to up_data.
REQ-016 rs_result  input  IMG_WIDTH  datapath result.
REQ-017 dn_data  output  IMG_WIDTH  downstream image word, FIFO head.
REQ-018 dn_valid / dn_rdy  output / input  1  downstream handshake.
REQ-019 busy  output  1  high when any word is in flight or in the FIFO.

Function
REQ-020 States: RUN, DRAIN, LOAD; reset state RUN.
REQ-021 Accept: up_rdy = (state==RUN) && (inflight + fifo_count < DEPTH).
REQ-022 Tag pipe: LATENCY-bit shift register; bit 0 loads (up_valid && up_rdy) each edge.
REQ-023 FIFO push when tag bit LATENCY-1 is set, writing rs_result; push is never refused, guaranteed by REQ-021 credit.
REQ-024 inflight = popcount of tag pipe; fifo_count 0..DEPTH, counter width clog2(DEPTH)+1.
REQ-025 Simultaneous push and pop: count unchanged, both performed; pop on empty is impossible (dn_valid=0).
REQ-026 Latency: a word accepted at edge k appears at dn_data with dn_valid after edge k+LATENCY when the FIFO is empty.
REQ-027 Order preserved: dn words leave in upstream acceptance order.
REQ-028 RUN, cfg_valid=1 -> DRAIN; up_rdy=0 from that cycle on.
REQ-029 DRAIN: wait until inflight==0, then -> LOAD; FIFO contents and downstream pops continue unaffected.
REQ-030 LOAD (one cycle): rs_shift <= min(cfg_shift, NUM_WIDTH-IMG_WIDTH); cfg_ready=1; cfg_clamp set if clamped; -> RUN.
REQ-031 If cfg_valid and up_valid rise in the same RUN cycle, the configuration wins and no upstream word is accepted.
REQ-032 If cfg_valid is asserted in DRAIN with inflight already 0, transition to LOAD occurs on the next edge.
REQ-033 cfg_clamp clears only on reset.
REQ-034 busy = (inflight != 0) || (fifo_count != 0).

Reset
REQ-035 Upon rst_n low, immediately and asynchronously: state=RUN, tag pipe=0, FIFO pointers/count=0, rs_shift=0, cfg_clamp=0.
REQ-036 Outputs during reset: up_rdy=0, dn_valid=0, cfg_ready=0, busy=0.
REQ-037 Reset mid-operation discards all in-flight and buffered words; no stale dn_valid after release.
REQ-038 up_rdy rises no earlier than the first edge after rst_n deasserts.

Verification
REQ-039 Stream 20 words, dn_rdy=1, rs_shift=0, model datapath with 4-cycle delay -> 20 outputs in order, first dn_valid 4 cycles after first acceptance.
REQ-040 dn_rdy=0, continuous up_valid -> up_rdy drops after exactly 8 acceptances; no FIFO overflow; all 8 words drain in order once dn_rdy=1.
REQ-041 cfg_shift=5 with 3 words in flight -> up_rdy=0 immediately; cfg_ready pulses one cycle after the last tag leaves; rs_shift=5; streaming resumes.
REQ-042 cfg_shift=40 (NUM_WIDTH=33, IMG_WIDTH=16) -> rs_shift=17; cfg_clamp=1 and stays 1.
REQ-043 rst_n pulsed low with 5 words buffered -> dn_valid=0 and busy=0 immediately; after release, no old words emerge.
REQ-044 Random up_valid and dn_rdy for 10k cycles against a scoreboard -> no loss, duplication or reordering; fifo_count never exceeds DEPTH.

Source files
------------

// File: rtl/rescale_ctrl_if.sv
// Handshake bundle between rescale_ctrl and its surroundings: configuration,
// upstream number stream, rescale datapath and downstream image stream.
interface rescale_ctrl_if #(
    parameter int unsigned NUM_WIDTH = 33,
    parameter int unsigned IMG_WIDTH = 16
);
    logic [7:0]           cfg_shift;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic                 cfg_clamp;
    logic [NUM_WIDTH-1:0] up_data;
    logic                 up_valid;
    logic                 up_rdy;
    logic [7:0]           rs_shift;
    logic [NUM_WIDTH-1:0] rs_data;
    logic [IMG_WIDTH-1:0] rs_result;
    logic [IMG_WIDTH-1:0] dn_data;
    logic                 dn_valid;
    logic                 dn_rdy;
    logic                 busy;

    // Controller side
    modport slave (
        input  cfg_shift, cfg_valid, up_data, up_valid, rs_result, dn_rdy,
        output cfg_ready, cfg_clamp, up_rdy, rs_shift, rs_data, dn_data, dn_valid, busy
    );

    // Environment side
    modport master (
        output cfg_shift, cfg_valid, up_data, up_valid, rs_result, dn_rdy,
        input  cfg_ready, cfg_clamp, up_rdy, rs_shift, rs_data, dn_data, dn_valid, busy
    );
endinterface

// File: rtl/rescale_ctrl.sv
// Rescale controller: feeds a fixed-latency rescale datapath, tracks words in
// flight with a tag pipe, buffers results in a credit-protected FIFO and
// applies shift updates only once the datapath has drained.
module rescale_ctrl #(
    parameter int unsigned NUM_WIDTH = 33,
    parameter int unsigned IMG_WIDTH = 16,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned DEPTH     = 8
) (
    input logic           clk,
    input logic           rst_n,
    rescale_ctrl_if.slave bus_io
);

    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam int unsigned CntW     = $clog2(DEPTH) + 1;
    localparam int unsigned SumW     = CntW + 1;
    localparam int unsigned MaxShift = NUM_WIDTH - IMG_WIDTH;

    typedef enum logic [1:0] {StRun, StDrain, StLoad} state_e;

    state_e               state_q;
    logic                 cfg_ready_q;
    logic                 cfg_clamp_q;
    logic [7:0]           rs_shift_q;
    logic                 rdy_en_q;

    logic [LATENCY-1:0]   tag_q, tag_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [IMG_WIDTH-1:0] mem_q [DEPTH];

    logic [SumW-1:0]      inflight;
    logic                 credit_ok;
    logic                 up_rdy;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 dn_valid;
    logic                 shift_clamp;
    logic [7:0]           shift_sat;

    // Credit: words in the datapath plus words buffered must leave FIFO room
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            inflight = inflight + SumW'(tag_q[i]);
        end
        credit_ok = (inflight + SumW'(fifo_cnt_q)) < SumW'(DEPTH);
    end

    // Handshake decode; a pending cfg request blocks upstream in the same cycle.
    // rdy_en_q keeps up_rdy low until the first edge after reset release.
    always_comb begin
        up_rdy   = rdy_en_q && (state_q == StRun) && !bus_io.cfg_valid && credit_ok;
        accept   = bus_io.up_valid && up_rdy;
        push     = tag_q[LATENCY-1];
        dn_valid = (fifo_cnt_q != '0);
        pop      = dn_valid && bus_io.dn_rdy;
    end

    // Next state for tag pipe and FIFO pointers/count
    always_comb begin
        tag_d    = (tag_q << 1) | LATENCY'(accept);
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Tag pipe and FIFO bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care until the count covers them
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_io.rs_result;
        end
    end

    // Saturate the requested shift to what the datapath can represent
    always_comb begin
        shift_clamp = 32'(bus_io.cfg_shift) > MaxShift;
        shift_sat   = shift_clamp ? 8'(MaxShift) : bus_io.cfg_shift;
    end

    // Control FSM with registered cfg_ready, rs_shift and sticky clamp flag.
    // cfg_ready is high during LOAD; cfg_shift is sampled at the LOAD exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            cfg_ready_q <= 1'b0;
            cfg_clamp_q <= 1'b0;
            rs_shift_q  <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            rdy_en_q    <= 1'b1;
            cfg_ready_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (bus_io.cfg_valid) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (tag_q == '0) begin
                        state_q     <= StLoad;
                        cfg_ready_q <= 1'b1;
                    end
                end
                StLoad: begin
                    rs_shift_q <= shift_sat;
                    if (shift_clamp) begin
                        cfg_clamp_q <= 1'b1;
                    end
                    state_q <= StRun;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus_io.up_rdy    = up_rdy;
    assign bus_io.rs_data   = bus_io.up_data;
    assign bus_io.rs_shift  = rs_shift_q;
    assign bus_io.cfg_ready = cfg_ready_q;
    assign bus_io.cfg_clamp = cfg_clamp_q;
    assign bus_io.dn_data   = mem_q[rd_ptr_q];
    assign bus_io.dn_valid  = dn_valid;
    assign bus_io.busy      = (tag_q != '0) || (fifo_cnt_q != '0);

endmodule
